// File: rtl/mips_run_monitor.sv
// mips_run_monitor: cycle/instruction/store counters with a sticky PASS/FAIL/TIMEOUT verdict; STORE_LOG_EN adds a circular store log
module mips_run_monitor #(
    parameter int          CNT_W        = 16,
    parameter int          LIMIT        = 200,
    parameter logic [31:0] PASS_ADDR    = 32'd84,
    parameter logic [31:0] PASS_DATA    = 32'd7,
    parameter logic [31:0] ALLOW_ADDR   = 32'd80,
    parameter logic [31:0] REPEAT_INSTR = 32'h00000020,
    parameter int          LOG_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  instr,
    input  logic                         memwrite,
    input  logic [31:0]                  dataadr,
    input  logic [31:0]                  writedata,
    input  logic [$clog2(LOG_DEPTH)-1:0] log_idx,
    output logic                         done,
    output logic                         pass,
    output logic [1:0]                   status,
    output logic [CNT_W-1:0]             cyc_cnt,
    output logic [CNT_W-1:0]             instr_cnt,
    output logic [CNT_W-1:0]             store_cnt,
    output logic [31:0]                  fail_addr,
    output logic [31:0]                  fail_data,
    output logic [31:0]                  log_addr,
    output logic [31:0]                  log_data,
    output logic [$clog2(LOG_DEPTH):0]   log_cnt
);
    localparam int LW = $clog2(LOG_DEPTH);

    typedef enum logic [1:0] {RUN = 2'b00, PASS = 2'b01, FAIL = 2'b10, TIMEOUT = 2'b11} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d, icnt_q, icnt_d, scnt_q, scnt_d;
    logic [31:0]       last_instr_q, last_instr_d, fail_addr_q, fail_addr_d, fail_data_q, fail_data_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction

    // Next-state and counter updates; everything holds once a verdict is reached
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        icnt_d       = icnt_q;
        scnt_d       = scnt_q;
        last_instr_d = last_instr_q;
        fail_addr_d  = fail_addr_q;
        fail_data_d  = fail_data_q;
        if (state_q == RUN) begin
            cyc_d        = sat_inc(cyc_q);
            icnt_d       = (instr == REPEAT_INSTR || instr != last_instr_q) ? sat_inc(icnt_q) : icnt_q;
            last_instr_d = instr;
            if (memwrite) begin
                scnt_d = sat_inc(scnt_q);
                if (dataadr == PASS_ADDR && writedata == PASS_DATA) begin
                    state_d = PASS;
                end else if (dataadr != ALLOW_ADDR) begin
                    state_d     = FAIL;
                    fail_addr_d = dataadr;
                    fail_data_d = writedata;
                end
            end
            if (state_d == RUN && cyc_d == CNT_W'(LIMIT))
                state_d = TIMEOUT;
        end
    end

    // Verdict and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            cyc_q        <= '0;
            icnt_q       <= '0;
            scnt_q       <= '0;
            last_instr_q <= '0;
            fail_addr_q  <= '0;
            fail_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            icnt_q       <= icnt_d;
            scnt_q       <= scnt_d;
            last_instr_q <= last_instr_d;
            fail_addr_q  <= fail_addr_d;
            fail_data_q  <= fail_data_d;
        end
    end

    assign status    = state_q;
    assign done      = state_q != RUN;
    assign pass      = state_q == PASS;
    assign cyc_cnt   = cyc_q;
    assign instr_cnt = icnt_q;
    assign store_cnt = scnt_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

`ifdef STORE_LOG_EN
    logic [LOG_DEPTH-1:0][31:0] la_q, la_d, ld_q, ld_d;
    logic [LW-1:0]              wp_q, wp_d, rd_ptr;
    logic [LW:0]                lc_q, lc_d;

    // Append every RUN-state store, including the terminating one
    always_comb begin
        la_d = la_q;
        ld_d = ld_q;
        wp_d = wp_q;
        lc_d = lc_q;
        if (state_q == RUN && memwrite) begin
            la_d[wp_q] = dataadr;
            ld_d[wp_q] = writedata;
            wp_d       = wp_q + 1'b1;
            lc_d       = (lc_q == (LW+1)'(LOG_DEPTH)) ? lc_q : lc_q + 1'b1;
        end
    end

    // Log storage registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            la_q <= '0;
            ld_q <= '0;
            wp_q <= '0;
            lc_q <= '0;
        end else begin
            la_q <= la_d;
            ld_q <= ld_d;
            wp_q <= wp_d;
            lc_q <= lc_d;
        end
    end

    assign rd_ptr   = wp_q - 1'b1 - log_idx;
    assign log_addr = ({1'b0, log_idx} < lc_q) ? la_q[rd_ptr] : '0;
    assign log_data = ({1'b0, log_idx} < lc_q) ? ld_q[rd_ptr] : '0;
    assign log_cnt  = lc_q;
`else
    logic unused_log_idx;
    assign unused_log_idx = ^log_idx;
    assign log_addr = '0;
    assign log_data = '0;
    assign log_cnt  = '0;
`endif
endmodule

// File: tb/tb_mips_run_monitor.sv
// tb_mips_run_monitor: directed vector table plus hand-written verdict, timeout, reset and log sequences
module tb_mips_run_monitor;
    logic        clk = 1'b0, reset = 1'b1, memwrite = 1'b0;
    logic [31:0] instr = '0, dataadr = '0, writedata = '0;
    logic [1:0]  log_idx = '0;
    logic        done, pass;
    logic [1:0]  status;
    logic [15:0] cyc_cnt, instr_cnt, store_cnt;
    logic [31:0] fail_addr, fail_data, log_addr, log_data;
    logic [2:0]  log_cnt;
    int n_cmp = 0, n_bad = 0;

    mips_run_monitor dut (
        .clk(clk), .reset(reset), .instr(instr), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .log_idx(log_idx), .done(done), .pass(pass), .status(status),
        .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt), .store_cnt(store_cnt), .fail_addr(fail_addr),
        .fail_data(fail_data), .log_addr(log_addr), .log_data(log_data), .log_cnt(log_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        mw;
        logic [31:0] adr, dat;
        logic [1:0]  st;
        int          cyc, ic, sc;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d);
        memwrite  = mw;
        dataadr   = a;
        writedata = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 0, 0);
        instr = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{32'h20,       1'b0, 32'd0,  32'd0, 2'd0, 1,  1, 0};
        tbl[1]  = '{32'h20,       1'b0, 32'd0,  32'd0, 2'd0, 2,  2, 0};
        tbl[2]  = '{32'h20,       1'b0, 32'd0,  32'd0, 2'd0, 3,  3, 0};
        tbl[3]  = '{32'h20,       1'b0, 32'd0,  32'd0, 2'd0, 4,  4, 0};
        tbl[4]  = '{32'h20,       1'b0, 32'd0,  32'd0, 2'd0, 5,  5, 0};
        tbl[5]  = '{32'h8C100004, 1'b0, 32'd0,  32'd0, 2'd0, 6,  6, 0};
        tbl[6]  = '{32'h8C100004, 1'b0, 32'd0,  32'd0, 2'd0, 7,  6, 0};
        tbl[7]  = '{32'h8C100004, 1'b0, 32'd0,  32'd0, 2'd0, 8,  6, 0};
        tbl[8]  = '{32'h8C100004, 1'b1, 32'd80, 32'd3, 2'd0, 9,  6, 1};
        tbl[9]  = '{32'h1234,     1'b0, 32'd0,  32'd0, 2'd0, 10, 7, 1};
        tbl[10] = '{32'h1234,     1'b1, 32'd84, 32'd7, 2'd1, 11, 7, 2};
        tbl[11] = '{32'h20,       1'b1, 32'd88, 32'd5, 2'd1, 11, 7, 2};

        do_reset();
        chk("reset_status", 32'(status), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_cyc", 32'(cyc_cnt), 0);
        chk("reset_fail_addr", fail_addr, 0);

        for (int i = 0; i < 12; i++) begin
            instr = tbl[i].instr;
            drive(tbl[i].mw, tbl[i].adr, tbl[i].dat);
            step();
            chk($sformatf("v%0d_status", i), 32'(status), 32'(tbl[i].st));
            chk($sformatf("v%0d_cyc", i), 32'(cyc_cnt), tbl[i].cyc);
            chk($sformatf("v%0d_instr", i), 32'(instr_cnt), tbl[i].ic);
            chk($sformatf("v%0d_store", i), 32'(store_cnt), tbl[i].sc);
        end
        chk("pass_flag", 32'(pass), 1);
        chk("pass_done", 32'(done), 1);

        do_reset();
        step();
        drive(1'b1, 88, 5);
        step();
        chk("bad_addr_status", 32'(status), 2);
        chk("bad_addr_fa", fail_addr, 88);
        chk("bad_addr_fd", fail_data, 5);
        chk("bad_addr_pass", 32'(pass), 0);
        drive(1'b1, 84, 7);
        step();
        chk("after_fail_status", 32'(status), 2);
        chk("after_fail_store", 32'(store_cnt), 1);
        chk("after_fail_cyc", 32'(cyc_cnt), 2);

        do_reset();
        drive(1'b1, 84, 6);
        step();
        chk("bad_data_status", 32'(status), 2);
        chk("bad_data_fa", fail_addr, 84);
        chk("bad_data_fd", fail_data, 6);

        do_reset();
        repeat (199) step();
        chk("pre_limit_status", 32'(status), 0);
        chk("pre_limit_cyc", 32'(cyc_cnt), 199);
        step();
        chk("timeout_status", 32'(status), 3);
        chk("timeout_cyc", 32'(cyc_cnt), 200);
        repeat (3) step();
        chk("timeout_frozen", 32'(cyc_cnt), 200);

        do_reset();
        repeat (199) step();
        drive(1'b1, 84, 7);
        step();
        chk("limit_pass_status", 32'(status), 1);
        chk("limit_pass_cyc", 32'(cyc_cnt), 200);
        chk("limit_pass_store", 32'(store_cnt), 1);

        do_reset();
        repeat (199) step();
        drive(1'b1, 96, 9);
        step();
        chk("limit_fail_status", 32'(status), 2);
        chk("limit_fail_fa", fail_addr, 96);

        do_reset();
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 80, i);
            step();
        end
        drive(1'b0, 0, 0);
        chk("six_store_cnt", 32'(store_cnt), 6);
        chk("six_status", 32'(status), 0);
`ifdef STORE_LOG_EN
        chk("log_cnt", 32'(log_cnt), 4);
        log_idx = 2'd0;
        #1 chk("log_idx0_data", log_data, 6);
        chk("log_idx0_addr", log_addr, 80);
        log_idx = 2'd3;
        #1 chk("log_idx3_data", log_data, 3);
        log_idx = 2'd1;
        #1 chk("log_idx1_data", log_data, 5);
`else
        chk("nolog_cnt", 32'(log_cnt), 0);
        chk("nolog_data", log_data, 0);
        chk("nolog_addr", log_addr, 0);
`endif
        reset = 1'b1;
        #1;
        chk("async_rst_status", 32'(status), 0);
        chk("async_rst_cyc", 32'(cyc_cnt), 0);
        chk("async_rst_store", 32'(store_cnt), 0);
        chk("async_rst_log_cnt", 32'(log_cnt), 0);
        log_idx = 2'd0;
        #1 chk("async_rst_log_data", log_data, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
